// File: rtl/hdmi_packet_parser.sv
// HDMI data-island packet parser (sink side).
// Accepts ECC-checked packets one strobe at a time and dispatches on HB0:
// ACR -> N/CTS, Audio Sample -> per-sample FIFO, AVI/Audio InfoFrames ->
// checksummed, held fields with per-field loss detection.
module hdmi_packet_parser #(
    parameter int AUDIO_BIT_WIDTH   = 16,
    parameter int FIFO_DEPTH        = 8,
    parameter int INFOFRAME_TIMEOUT = 2
) (
    input  logic                       clk_pixel,
    input  logic                       reset,
    input  logic                       video_field_end,
    input  logic                       pkt_valid,
    input  logic [23:0]                pkt_header,
    input  logic [3:0][55:0]           pkt_sub,
    input  logic [4:0]                 pkt_ecc_err,
    output logic                       aud_valid,
    input  logic                       aud_ready,
    output logic [AUDIO_BIT_WIDTH-1:0] aud_left,
    output logic [AUDIO_BIT_WIDTH-1:0] aud_right,
    output logic                       aud_block_start,
    output logic                       aud_overflow,
    output logic                       acr_valid,
    output logic [19:0]                acr_n,
    output logic [19:0]                acr_cts,
    output logic                       avi_valid,
    output logic [6:0]                 avi_vic,
    output logic                       aif_valid,
    output logic [2:0]                 aif_channel_count,
    output logic [7:0]                 err_count
);

    localparam int              PTR_W         = $clog2(FIFO_DEPTH);
    localparam int              CNT_W         = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT   = CNT_W'(FIFO_DEPTH);
    localparam logic [3:0]      TIMEOUT_LIMIT = 4'(INFOFRAME_TIMEOUT);
    localparam logic [7:0]      TYPE_ACR      = 8'h01;
    localparam logic [7:0]      TYPE_AUDIO    = 8'h02;
    localparam logic [7:0]      TYPE_AVI      = 8'h82;
    localparam logic [7:0]      TYPE_AIF      = 8'h84;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_PUSH   = 2'd2
    } state_t;

    // 8-bit sum of the three header bytes and all 28 subpacket bytes.
    function automatic logic [7:0] calc_checksum(input logic [23:0] hdr,
                                                 input logic [3:0][55:0] sub);
        logic [7:0] sum;
        sum = hdr[7:0] + hdr[15:8] + hdr[23:16];
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 7; j++) begin
                sum = sum + sub[i][j*8 +: 8];
            end
        end
        return sum;
    endfunction

    // Index of the lowest pending subpacket (caller guarantees mask != 0).
    function automatic logic [1:0] first_set(input logic [3:0] mask);
        if (mask[0]) begin
            return 2'd0;
        end else if (mask[1]) begin
            return 2'd1;
        end else if (mask[2]) begin
            return 2'd2;
        end else begin
            return 2'd3;
        end
    endfunction

    // Field counter increment that sticks at its maximum.
    function automatic logic [3:0] sat_inc4(input logic [3:0] c);
        if (c == 4'hF) begin
            return c;
        end else begin
            return c + 4'd1;
        end
    endfunction

    state_t                     state_r, state_next_s;
    logic [23:0]                hdr_r;
    logic [3:0][55:0]           sub_r;
    logic [4:0]                 ecc_r;
    logic [3:0]                 pend_r;

    logic                       capture_s, busy_drop_s, drop_s;
    logic                       acr_load_s, avi_load_s, aif_load_s, aud_start_s;
    logic                       push_s;
    logic [1:0]                 push_idx_s;
    logic [3:0]                 pend_next_s;
    logic [1:0]                 err_inc_s;
    logic [3:0]                 hb2_s;
    logic [7:0]                 type_s;

    logic [AUDIO_BIT_WIDTH-1:0] left_mem  [FIFO_DEPTH];
    logic [AUDIO_BIT_WIDTH-1:0] right_mem [FIFO_DEPTH];
    logic                       b_mem     [FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]           count_r;
    logic                       overflow_r;
    logic                       full_s, pop_s, push_ok_s, lost_s;

    logic                       acr_valid_r;
    logic [19:0]                acr_n_r, acr_cts_r;
    logic                       avi_valid_r, aif_valid_r;
    logic [6:0]                 avi_vic_r;
    logic [2:0]                 aif_chc_r;
    logic [3:0]                 avi_cnt_r, aif_cnt_r, avi_cnt_inc_s, aif_cnt_inc_s;
    logic [7:0]                 err_r;
    logic [8:0]                 err_sum_s;

    assign type_s = hdr_r[7:0];
    assign hb2_s  = hdr_r[19:16];

    // FSM state register.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (pkt_valid) begin
                    state_next_s = ST_DECODE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DECODE: begin
                if (aud_start_s) begin
                    state_next_s = ST_PUSH;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_PUSH: begin
                if (pend_next_s == 4'b0000) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_PUSH;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs: packet classification, drop decisions and push control.
    always_comb begin
        capture_s   = 1'b0;
        busy_drop_s = 1'b0;
        drop_s      = 1'b0;
        acr_load_s  = 1'b0;
        avi_load_s  = 1'b0;
        aif_load_s  = 1'b0;
        aud_start_s = 1'b0;
        push_s      = 1'b0;
        push_idx_s  = first_set(pend_r);
        pend_next_s = pend_r;
        case (state_r)
            ST_IDLE: begin
                capture_s = pkt_valid;
            end
            ST_DECODE: begin
                busy_drop_s = pkt_valid;
                if (ecc_r != 5'b00000) begin
                    drop_s = 1'b1;
                end else if (type_s == TYPE_AUDIO) begin
                    drop_s      = hdr_r[12];
                    aud_start_s = ~hdr_r[12] & (hdr_r[11:8] != 4'b0000);
                end else if ((type_s == TYPE_AVI) || (type_s == TYPE_AIF)) begin
                    drop_s     = (calc_checksum(hdr_r, sub_r) != 8'h00);
                    avi_load_s = (type_s == TYPE_AVI) & ~drop_s;
                    aif_load_s = (type_s == TYPE_AIF) & ~drop_s;
                end else begin
                    acr_load_s = (type_s == TYPE_ACR);
                end
            end
            ST_PUSH: begin
                busy_drop_s = pkt_valid;
                push_s      = 1'b1;
                pend_next_s = pend_r & ~(4'b0001 << push_idx_s);
            end
            default: begin
                busy_drop_s = pkt_valid;
            end
        endcase
        err_inc_s = {1'b0, drop_s} + {1'b0, busy_drop_s};
    end

    // Packet capture in IDLE and pending-sample bookkeeping during PUSH.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            hdr_r  <= 24'h000000;
            sub_r  <= {4{56'h0}};
            ecc_r  <= 5'b00000;
            pend_r <= 4'b0000;
        end else if (capture_s) begin
            hdr_r  <= pkt_header;
            sub_r  <= pkt_sub;
            ecc_r  <= pkt_ecc_err;
            pend_r <= pkt_header[11:8];
        end else if (push_s) begin
            pend_r <= pend_next_s;
        end
    end

    assign full_s    = (count_r == FULL_COUNT);
    assign pop_s     = (count_r != {CNT_W{1'b0}}) & aud_ready;
    assign push_ok_s = push_s & (~full_s | pop_s);
    assign lost_s    = push_s & full_s & ~pop_s;

    // Audio FIFO storage; samples are truncated to their top bits.
    always_ff @(posedge clk_pixel) begin
        if (push_ok_s) begin
            left_mem[wr_ptr_r]  <= sub_r[push_idx_s][23 -: AUDIO_BIT_WIDTH];
            right_mem[wr_ptr_r] <= sub_r[push_idx_s][47 -: AUDIO_BIT_WIDTH];
            b_mem[wr_ptr_r]     <= hb2_s[push_idx_s];
        end
    end

    // Audio FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            if (lost_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // ACR values and their one-cycle update strobe.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            acr_valid_r <= 1'b0;
            acr_n_r     <= 20'h00000;
            acr_cts_r   <= 20'h00000;
        end else begin
            acr_valid_r <= acr_load_s;
            if (acr_load_s) begin
                acr_cts_r <= {sub_r[0][11:8], sub_r[0][23:16], sub_r[0][31:24]};
                acr_n_r   <= {sub_r[0][35:32], sub_r[0][47:40], sub_r[0][55:48]};
            end
        end
    end

    assign avi_cnt_inc_s = sat_inc4(avi_cnt_r);
    assign aif_cnt_inc_s = sat_inc4(aif_cnt_r);

    // AVI InfoFrame fields and loss timer; a passing frame beats a field end.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            avi_valid_r <= 1'b0;
            avi_vic_r   <= 7'd0;
            avi_cnt_r   <= 4'd0;
        end else if (avi_load_s) begin
            avi_valid_r <= 1'b1;
            avi_vic_r   <= sub_r[0][38:32];
            avi_cnt_r   <= 4'd0;
        end else if (video_field_end) begin
            avi_cnt_r <= avi_cnt_inc_s;
            if (avi_cnt_inc_s >= TIMEOUT_LIMIT) begin
                avi_valid_r <= 1'b0;
            end
        end
    end

    // Audio InfoFrame fields and loss timer; a passing frame beats a field end.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            aif_valid_r <= 1'b0;
            aif_chc_r   <= 3'd0;
            aif_cnt_r   <= 4'd0;
        end else if (aif_load_s) begin
            aif_valid_r <= 1'b1;
            aif_chc_r   <= sub_r[0][10:8];
            aif_cnt_r   <= 4'd0;
        end else if (video_field_end) begin
            aif_cnt_r <= aif_cnt_inc_s;
            if (aif_cnt_inc_s >= TIMEOUT_LIMIT) begin
                aif_valid_r <= 1'b0;
            end
        end
    end

    assign err_sum_s = {1'b0, err_r} + {7'b0000000, err_inc_s};

    // Saturating count of dropped packets (up to two per cycle).
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            err_r <= 8'h00;
        end else if (err_sum_s[8]) begin
            err_r <= 8'hFF;
        end else begin
            err_r <= err_sum_s[7:0];
        end
    end

    assign aud_valid         = (count_r != {CNT_W{1'b0}});
    assign aud_left          = aud_valid ? left_mem[rd_ptr_r]  : {AUDIO_BIT_WIDTH{1'b0}};
    assign aud_right         = aud_valid ? right_mem[rd_ptr_r] : {AUDIO_BIT_WIDTH{1'b0}};
    assign aud_block_start   = aud_valid ? b_mem[rd_ptr_r]     : 1'b0;
    assign aud_overflow      = overflow_r;
    assign acr_valid         = acr_valid_r;
    assign acr_n             = acr_n_r;
    assign acr_cts           = acr_cts_r;
    assign avi_valid         = avi_valid_r;
    assign avi_vic           = avi_vic_r;
    assign aif_valid         = aif_valid_r;
    assign aif_channel_count = aif_chc_r;
    assign err_count         = err_r;

endmodule

// File: tb/tb_hdmi_packet_parser.sv
// Testbench for hdmi_packet_parser: a table of single-packet vectors plus
// hand-written audio / InfoFrame-loss / reset sequences, with an audio
// scoreboard queue checked as samples leave the FIFO.
module tb_hdmi_packet_parser;

    localparam int W = 16;

    logic             clk_pixel = 1'b0;
    logic             reset;
    logic             video_field_end;
    logic             pkt_valid;
    logic [23:0]      pkt_header;
    logic [3:0][55:0] pkt_sub;
    logic [4:0]       pkt_ecc_err;
    logic             aud_valid;
    logic             aud_ready;
    logic [W-1:0]     aud_left;
    logic [W-1:0]     aud_right;
    logic             aud_block_start;
    logic             aud_overflow;
    logic             acr_valid;
    logic [19:0]      acr_n;
    logic [19:0]      acr_cts;
    logic             avi_valid;
    logic [6:0]       avi_vic;
    logic             aif_valid;
    logic [2:0]       aif_channel_count;
    logic [7:0]       err_count;

    always #5 clk_pixel = ~clk_pixel;

    hdmi_packet_parser #(
        .AUDIO_BIT_WIDTH(W),
        .FIFO_DEPTH(8),
        .INFOFRAME_TIMEOUT(2)
    ) dut (
        .clk_pixel(clk_pixel),
        .reset(reset),
        .video_field_end(video_field_end),
        .pkt_valid(pkt_valid),
        .pkt_header(pkt_header),
        .pkt_sub(pkt_sub),
        .pkt_ecc_err(pkt_ecc_err),
        .aud_valid(aud_valid),
        .aud_ready(aud_ready),
        .aud_left(aud_left),
        .aud_right(aud_right),
        .aud_block_start(aud_block_start),
        .aud_overflow(aud_overflow),
        .acr_valid(acr_valid),
        .acr_n(acr_n),
        .acr_cts(acr_cts),
        .avi_valid(avi_valid),
        .avi_vic(avi_vic),
        .aif_valid(aif_valid),
        .aif_channel_count(aif_channel_count),
        .err_count(err_count)
    );

    typedef struct {
        logic         b;
        logic [W-1:0] l;
        logic [W-1:0] r;
    } samp_t;

    typedef struct {
        logic [23:0] hdr;
        logic [55:0] sub0;
        logic [4:0]  ecc;
        int          csum_mode;   // 0 raw, 1 make checksum good, 2 make it bad
        logic        exp_acr;
        int          exp_err;
        logic [19:0] exp_n;
        logic [19:0] exp_cts;
        logic [6:0]  exp_vic;
        logic        exp_avi_v;
        logic [2:0]  exp_chc;
        logic        exp_aif_v;
    } vec_t;

    samp_t            exp_q[$];
    samp_t            mon_e;
    vec_t             vecs[9];
    logic [3:0][55:0] tv_sub;
    int               checks = 0;
    int               errors = 0;
    int               exp_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Fill SB0 of subpacket 0 so the whole packet sums to 0 (or to 1 when bad).
    function automatic logic [55:0] fix_sub0(input logic [23:0] hdr, input logic [55:0] s0, input int mode);
        logic [7:0]  sum;
        logic [55:0] o;
        o = s0;
        if (mode != 0) begin
            sum = hdr[7:0] + hdr[15:8] + hdr[23:16];
            for (int j = 1; j < 7; j++) sum = sum + s0[j*8 +: 8];
            o[7:0] = 8'h00 - sum;
            if (mode == 2) o[7:0] = o[7:0] + 8'h01;
        end
        return o;
    endfunction

    function automatic logic [55:0] aud_sub(input int k, input int i);
        logic [23:0] l;
        logic [23:0] r;
        l = {8'h12 + 8'(k), 8'h34 + 8'(i), 8'h56};
        r = {8'hAB, 8'hC0 + 8'(k), 8'h10 + 8'(i)};
        return {8'h00, r, l};
    endfunction

    // One-cycle packet strobe; returns one cycle after capture.
    task automatic drive_pkt(input logic [23:0] hdr, input logic [3:0][55:0] subs, input logic [4:0] ecc);
        pkt_header  = hdr;
        pkt_sub     = subs;
        pkt_ecc_err = ecc;
        pkt_valid   = 1'b1;
        tick();
        pkt_valid   = 1'b0;
        pkt_ecc_err = 5'b00000;
    endtask

    task automatic send_audio(input logic [7:0] hb1, input logic [7:0] hb2, input int k, input bit expect_store);
        logic [3:0][55:0] s;
        logic [55:0]      w;
        samp_t            e;
        for (int i = 0; i < 4; i++) s[i] = aud_sub(k, i);
        if (expect_store) begin
            for (int i = 0; i < 4; i++) begin
                if (hb1[i]) begin
                    w   = s[i];
                    e.b = hb2[i];
                    e.l = w[23:8];
                    e.r = w[47:32];
                    exp_q.push_back(e);
                end
            end
        end
        drive_pkt({hb2, hb1, 8'h02}, s, 5'b00000);
    endtask

    task automatic send_avi(input logic [6:0] vic, input bit fe_in_decode);
        logic [3:0][55:0] s;
        s    = {4{56'h0}};
        s[0] = fix_sub0(24'h0D0282, {8'h00, 8'h00, 1'b0, vic, 8'h00, 8'h00, 8'h10, 8'h00}, 1);
        drive_pkt(24'h0D0282, s, 5'b00000);
        video_field_end = fe_in_decode;
        tick();
        video_field_end = 1'b0;
        tick();
    endtask

    task automatic pulse_fe();
        video_field_end = 1'b1;
        tick();
        video_field_end = 1'b0;
        tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        aud_ready = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: compare each sample popped from the FIFO against the queue.
    always @(negedge clk_pixel) begin
        if (!reset && aud_valid && aud_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL aud_unexpected: got sample %0h/%0h expected none", aud_left, aud_right);
            end else begin
                mon_e = exp_q.pop_front();
                chk("aud_left", 32'(aud_left), 32'(mon_e.l));
                chk("aud_right", 32'(aud_right), 32'(mon_e.r));
                chk("aud_block_start", 32'(aud_block_start), 32'(mon_e.b));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{24'h000001, 56'h00_18_00_0A_22_01_00, 5'b00000, 0, 1'b1, 0, 20'd6144, 20'd74250, 7'd0,  1'b0, 3'd0, 1'b0};
        vecs[1] = '{24'h000001, 56'h00_10_00_78_69_00_00, 5'b00100, 0, 1'b0, 1, 20'd6144, 20'd74250, 7'd0,  1'b0, 3'd0, 1'b0};
        vecs[2] = '{24'h0D0282, 56'h00_00_10_00_00_10_00, 5'b00000, 1, 1'b0, 1, 20'd6144, 20'd74250, 7'd16, 1'b1, 3'd0, 1'b0};
        vecs[3] = '{24'h0D0282, 56'h00_00_1F_00_00_10_00, 5'b00000, 2, 1'b0, 2, 20'd6144, 20'd74250, 7'd16, 1'b1, 3'd0, 1'b0};
        vecs[4] = '{24'h0A0184, 56'h00_00_00_00_00_02_00, 5'b00000, 1, 1'b0, 2, 20'd6144, 20'd74250, 7'd16, 1'b1, 3'd2, 1'b1};
        vecs[5] = '{24'h000000, 56'h11_22_33_44_55_66_77, 5'b00000, 0, 1'b0, 2, 20'd6144, 20'd74250, 7'd16, 1'b1, 3'd2, 1'b1};
        vecs[6] = '{24'h0A0184, 56'h00_00_00_00_00_05_00, 5'b10000, 1, 1'b0, 3, 20'd6144, 20'd74250, 7'd16, 1'b1, 3'd2, 1'b1};
        vecs[7] = '{24'h001102, 56'h00_AB_CD_EF_12_34_56, 5'b00000, 0, 1'b0, 4, 20'd6144, 20'd74250, 7'd16, 1'b1, 3'd2, 1'b1};
        vecs[8] = '{24'h000001, 56'h00_10_00_78_69_00_00, 5'b01000, 0, 1'b0, 5, 20'd6144, 20'd74250, 7'd16, 1'b1, 3'd2, 1'b1};

        reset           = 1'b1;
        video_field_end = 1'b0;
        pkt_valid       = 1'b0;
        pkt_header      = 24'h000000;
        pkt_sub         = {4{56'h0}};
        pkt_ecc_err     = 5'b00000;
        aud_ready       = 1'b0;
        idle(3);
        chk("rst_aud_valid", 32'(aud_valid), 32'd0);
        chk("rst_aud_left", 32'(aud_left), 32'd0);
        chk("rst_overflow", 32'(aud_overflow), 32'd0);
        chk("rst_acr_valid", 32'(acr_valid), 32'd0);
        chk("rst_acr_n", 32'(acr_n), 32'd0);
        chk("rst_avi_valid", 32'(avi_valid), 32'd0);
        chk("rst_aif_valid", 32'(aif_valid), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        reset = 1'b0;
        idle(2);

        // Single-packet vectors: ACR, ECC drops, InfoFrame checksums, ignored types.
        for (int i = 0; i < 9; i++) begin
            tv_sub    = {4{56'h0}};
            tv_sub[0] = fix_sub0(vecs[i].hdr, vecs[i].sub0, vecs[i].csum_mode);
            drive_pkt(vecs[i].hdr, tv_sub, vecs[i].ecc);
            chk($sformatf("v%0d_acr_t1", i), 32'(acr_valid), 32'd0);
            tick();
            chk($sformatf("v%0d_acr_t2", i), 32'(acr_valid), 32'(vecs[i].exp_acr));
            tick();
            chk($sformatf("v%0d_acr_t3", i), 32'(acr_valid), 32'd0);
            chk($sformatf("v%0d_err", i), 32'(err_count), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_acr_n", i), 32'(acr_n), 32'(vecs[i].exp_n));
            chk($sformatf("v%0d_acr_cts", i), 32'(acr_cts), 32'(vecs[i].exp_cts));
            chk($sformatf("v%0d_avi_vic", i), 32'(avi_vic), 32'(vecs[i].exp_vic));
            chk($sformatf("v%0d_avi_valid", i), 32'(avi_valid), 32'(vecs[i].exp_avi_v));
            chk($sformatf("v%0d_aif_chc", i), 32'(aif_channel_count), 32'(vecs[i].exp_chc));
            chk($sformatf("v%0d_aif_valid", i), 32'(aif_valid), 32'(vecs[i].exp_aif_v));
            chk($sformatf("v%0d_aud_valid", i), 32'(aud_valid), 32'd0);
            idle(4);
            exp_err = vecs[i].exp_err;
        end

        // Audio latency, FIFO fill and overflow with the consumer stalled.
        aud_ready = 1'b0;
        send_audio(8'h0F, 8'h00, 0, 1'b1);
        tick();
        chk("aud_lat_t2", 32'(aud_valid), 32'd0);
        tick();
        chk("aud_lat_t3", 32'(aud_valid), 32'd1);
        chk("aud_head_left", 32'(aud_left), 32'h1234);
        idle(8);
        send_audio(8'h0F, 8'h00, 1, 1'b1);
        idle(8);
        chk("ovf_before", 32'(aud_overflow), 32'd0);
        send_audio(8'h0F, 8'h00, 2, 1'b0);
        idle(8);
        chk("ovf_after", 32'(aud_overflow), 32'd1);
        chk("ovf_err", 32'(err_count), 32'(exp_err));
        drain();
        chk("ovf_sticky", 32'(aud_overflow), 32'd1);

        // Sparse sample layout with a block-start flag on the first sample.
        send_audio(8'h05, 8'h01, 3, 1'b1);
        idle(8);
        drain();
        chk("sparse_err", 32'(err_count), 32'(exp_err));

        // InfoFrame loss detection and coincident refresh.
        pulse_fe();
        chk("loss_fe1", 32'(avi_valid), 32'd1);
        pulse_fe();
        chk("loss_fe2", 32'(avi_valid), 32'd0);
        chk("loss_vic_held", 32'(avi_vic), 32'd16);
        chk("loss_aif", 32'(aif_valid), 32'd0);
        chk("loss_chc_held", 32'(aif_channel_count), 32'd2);
        send_avi(7'd4, 1'b0);
        chk("refresh_valid", 32'(avi_valid), 32'd1);
        chk("refresh_vic", 32'(avi_vic), 32'd4);
        pulse_fe();
        send_avi(7'd4, 1'b1);
        chk("coinc_valid", 32'(avi_valid), 32'd1);
        pulse_fe();
        chk("coinc_cleared", 32'(avi_valid), 32'd1);
        pulse_fe();
        chk("coinc_timeout", 32'(avi_valid), 32'd0);

        // Packet arriving during PUSH is dropped; the audio packet still completes.
        aud_ready = 1'b1;
        send_audio(8'h0F, 8'h00, 4, 1'b1);
        tick();
        tv_sub    = {4{56'h0}};
        tv_sub[0] = 56'h00_10_00_78_69_00_00;
        drive_pkt(24'h000001, tv_sub, 5'b00000);
        exp_err++;
        idle(8);
        chk("busy_err", 32'(err_count), 32'(exp_err));
        chk("busy_acr_n", 32'(acr_n), 32'd6144);
        chk("busy_acr_cts", 32'(acr_cts), 32'd74250);
        drain();

        // Error counter saturation.
        for (int i = 0; i < 260; i++) begin
            drive_pkt(24'h000001, {4{56'h0}}, 5'b00001);
            tick();
        end
        chk("err_saturate", 32'(err_count), 32'd255);

        // Reset in the middle of a PUSH discards the rest of the packet.
        aud_ready = 1'b0;
        send_audio(8'h0F, 8'h00, 5, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_aud_valid", 32'(aud_valid), 32'd0);
        chk("mid_rst_err", 32'(err_count), 32'd0);
        chk("mid_rst_acr_n", 32'(acr_n), 32'd0);
        chk("mid_rst_avi_vic", 32'(avi_vic), 32'd0);
        chk("mid_rst_overflow", 32'(aud_overflow), 32'd0);
        idle(6);
        chk("mid_rst_no_push", 32'(aud_valid), 32'd0);
        aud_ready = 1'b1;
        idle(4);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
